mem_access_unit: RTL

- Responder side of the control unit's memory controls (MemRead, MemWrite, MemToReg, RegWrite).
- Accepts one load, store or ALU writeback per operation from the execute stage.
- Drives a variable-latency data-memory req/ack handshake and stalls the core while the access is outstanding.
- Produces the register-file writeback for loads and ALU results.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/mem_timeout_counter.sv | 27 ++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the core's memory-access path: default widths,
// control-decoder op kinds and the memory access unit state encoding.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 16;
    localparam int CPU_REG_AW = 4;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ALU,
        OP_LOAD,
        OP_STORE,
        OP_ILLEGAL
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_WB
    } mau_state_e;

    // Read and write together is never a legal control word.
    function automatic mem_op_e decode_mem_op(input logic rd, input logic wr, input logic rw);
        if (rd && wr) return OP_ILLEGAL;
        if (rd)       return OP_LOAD;
        if (wr)       return OP_STORE;
        if (rw)       return OP_ALU;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Up-counter bounding how long a memory access may wait for its ack;
// expired is high while the count sits at TIMEOUT-1.
module mem_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Executes one load, store or ALU writeback per operation over a req/ack
// data-memory handshake, stalling the core while an access is outstanding.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | accepting a new op from execute; stall low
//   ST_BUSY | mem_req held with stable we/addr/wdata, waiting for ack
//   ST_WB   | load data captured; writeback issued on the way to IDLE
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int REG_AW  = CPU_REG_AW,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [REG_AW-1:0] dest_reg,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    mau_state_e        state;
    mem_op_e           op;
    logic              load_keep;
    logic [REG_AW-1:0] dest_q;
    logic [DATA_W-1:0] rdata_q;
    logic              cnt_clear;
    logic              cnt_enable;
    logic              expired;

    assign op         = decode_mem_op(mem_read, mem_write, reg_write);
    assign stall      = (state != ST_IDLE);
    assign cnt_clear  = (state != ST_BUSY);
    assign cnt_enable = (state == ST_BUSY) && !mem_ack;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_en     <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            err       <= 1'b0;
            load_keep <= 1'b0;
            dest_q    <= '0;
            rdata_q   <= '0;
        end else begin
            wb_en <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (op)
                        OP_ILLEGAL: err <= 1'b1;
                        OP_LOAD: begin
                            state     <= ST_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= addr;
                            dest_q    <= dest_reg;
                            load_keep <= mem_to_reg;
                        end
                        OP_STORE: begin
                            state     <= ST_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= wdata;
                            load_keep <= 1'b0;
                        end
                        OP_ALU: begin
                            wb_en   <= 1'b1;
                            wb_reg  <= dest_reg;
                            wb_data <= alu_result;
                        end
                        default: ;
                    endcase
                end
                ST_BUSY: begin
                    // An ack arriving on the expiry cycle still completes the access.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_WB;
                            rdata_q <= mem_rdata;
                        end
                    end else if (expired) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    // Loads with mem_to_reg low keep the same timing but write nothing.
                    if (load_keep) begin
                        wb_en   <= 1'b1;
                        wb_reg  <= dest_q;
                        wb_data <= rdata_q;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
